// File: rtl/dma_pkg.sv
// Shared definitions for the descriptor fetch master: FSM encoding, descriptor layout, limits.
package dma_pkg;

    localparam int unsigned RTY_MAX_DEF = 4;
    localparam int unsigned TMO_MAX_DEF = 255;

    localparam logic [2:0] ST_IDLE  = 3'b000;
    localparam logic [2:0] ST_FETCH = 3'b001;
    localparam logic [2:0] ST_HOLD  = 3'b010;
    localparam logic [2:0] ST_ERR   = 3'b100;

    localparam int unsigned DESC_WORDS = 4;

    // Beat index of each descriptor word; byte offset is index * 4.
    localparam logic [1:0] WORD_CTRL = 2'd0;
    localparam logic [1:0] WORD_ADDR = 2'd1;
    localparam logic [1:0] WORD_NEXT = 2'd2;
    localparam logic [1:0] WORD_LEN  = 2'(DESC_WORDS - 1);

    typedef struct packed {
        logic [15:0] id;
        logic [7:0]  state;
        logic [5:0]  rsvd;
        logic        irq;
        logic        last;
    } desc_ctrl_t;

    function automatic logic [31:0] word_ofs(input logic [1:0] idx);
        return {28'd0, idx, 2'b00};
    endfunction

endpackage

// File: rtl/desc_beat_timer.sv
// Per-beat retry and wait counters; flags the cycle in which a limit would be crossed.
module desc_beat_timer
    import dma_pkg::*;
#(
    parameter int unsigned RTY_MAX = RTY_MAX_DEF,
    parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
    input  logic wb_clk_i,
    input  logic wb_rst_i,
    input  logic beat_start,
    input  logic rty_hit,
    input  logic wait_tick,
    output logic retry_exhausted_c,
    output logic timeout_c
);

    localparam int unsigned RTY_W = $clog2(RTY_MAX + 1);
    localparam int unsigned TMO_W = $clog2(TMO_MAX + 1);

    logic [RTY_W-1:0] rty_cnt;
    logic [TMO_W-1:0] wait_cnt;

    // A retry reissues the beat, so it restarts the wait window too.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rty_cnt  <= '0;
            wait_cnt <= '0;
        end else if (beat_start) begin
            rty_cnt  <= '0;
            wait_cnt <= '0;
        end else if (rty_hit) begin
            rty_cnt  <= rty_cnt + RTY_W'(1);
            wait_cnt <= '0;
        end else if (wait_tick) begin
            wait_cnt <= wait_cnt + TMO_W'(1);
        end
    end

    assign retry_exhausted_c = (rty_cnt == RTY_W'(RTY_MAX - 1));
    assign timeout_c         = (wait_cnt == TMO_W'(TMO_MAX - 1));

endmodule

// File: rtl/desc_fetch_master.sv
// Wishbone master that fetches 4-word DMA descriptors and hands them to a consumer.
module desc_fetch_master
    import dma_pkg::*;
#(
    parameter int unsigned RTY_MAX = RTY_MAX_DEF,
    parameter int unsigned TMO_MAX = TMO_MAX_DEF
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        enable,
    input  logic        ndar_dirty,
    input  logic [28:0] ndar,
    output logic        ndar_dirty_clear,
    output logic [31:0] wbm_adr_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic        wbm_cab_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_rty_i,
    output logic        desc_valid,
    input  logic        desc_ready,
    output logic [31:0] desc_ctrl,
    output logic [28:0] desc_addr,
    output logic [28:0] desc_next,
    output logic [23:0] desc_len,
    output logic        fetch_err
);

    logic [2:0]  state_q, state_d;
    logic [31:0] base_q, base_d;
    logic [31:0] adr_q, adr_d;
    logic [1:0]  beat_q, beat_d;
    logic        gap_q, gap_d;
    logic        cyc_q, cyc_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        clr_q, clr_d;
    desc_ctrl_t  ctrl_q, ctrl_d;
    logic [28:0] addr_q, addr_d;
    logic [28:0] next_q, next_d;
    logic [23:0] len_q, len_d;

    logic        start_c;
    logic [31:0] start_adr_c;
    logic        beat_start_c, rty_hit_c, wait_tick_c;
    logic        retry_exhausted_c, timeout_c;

    desc_beat_timer #(
        .RTY_MAX (RTY_MAX),
        .TMO_MAX (TMO_MAX)
    ) u_timer (
        .wb_clk_i          (wb_clk_i),
        .wb_rst_i          (wb_rst_i),
        .beat_start        (beat_start_c),
        .rty_hit           (rty_hit_c),
        .wait_tick         (wait_tick_c),
        .retry_exhausted_c (retry_exhausted_c),
        .timeout_c         (timeout_c)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            base_q  <= '0;
            adr_q   <= '0;
            beat_q  <= '0;
            gap_q   <= 1'b0;
            cyc_q   <= 1'b0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            clr_q   <= 1'b0;
            ctrl_q  <= '0;
            addr_q  <= '0;
            next_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            adr_q   <= adr_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            cyc_q   <= cyc_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            clr_q   <= clr_d;
            ctrl_q  <= ctrl_d;
            addr_q  <= addr_d;
            next_q  <= next_d;
            len_q   <= len_d;
        end
    end

    // Next-state and next-output logic; enable low overrides every state.
    always_comb begin
        state_d      = state_q;
        base_d       = base_q;
        adr_d        = adr_q;
        beat_d       = beat_q;
        gap_d        = 1'b0;
        cyc_d        = cyc_q;
        valid_d      = valid_q;
        ferr_d       = ferr_q;
        clr_d        = 1'b0;
        ctrl_d       = ctrl_q;
        addr_d       = addr_q;
        next_d       = next_q;
        len_d        = len_q;
        start_c      = 1'b0;
        start_adr_c  = {ndar, 3'b000};
        beat_start_c = 1'b0;
        rty_hit_c    = 1'b0;
        wait_tick_c  = 1'b0;

        if (!enable) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            valid_d = 1'b0;
            ferr_d  = 1'b0;
            beat_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cyc_d   = 1'b0;
                    valid_d = 1'b0;
                    if (ndar_dirty) begin
                        start_c = 1'b1;
                        clr_d   = 1'b1;
                    end
                end
                ST_FETCH: begin
                    if (gap_q) begin
                        cyc_d = 1'b1;
                    end else if (wbm_err_i) begin
                        state_d = ST_ERR;
                        cyc_d   = 1'b0;
                        ferr_d  = 1'b1;
                    end else if (wbm_ack_i) begin
                        case (beat_q)
                            WORD_CTRL: ctrl_d = desc_ctrl_t'(wbm_dat_i);
                            WORD_ADDR: addr_d = wbm_dat_i[31:3];
                            WORD_NEXT: next_d = wbm_dat_i[31:3];
                            default:   len_d  = wbm_dat_i[23:0];
                        endcase
                        if (beat_q == WORD_LEN) begin
                            state_d = ST_HOLD;
                            cyc_d   = 1'b0;
                            valid_d = 1'b1;
                        end else begin
                            beat_d       = beat_q + 2'd1;
                            adr_d        = base_q + word_ofs(beat_q + 2'd1);
                            beat_start_c = 1'b1;
                        end
                    end else if (wbm_rty_i) begin
                        if (retry_exhausted_c) begin
                            state_d = ST_ERR;
                            cyc_d   = 1'b0;
                            ferr_d  = 1'b1;
                        end else begin
                            rty_hit_c = 1'b1;
                            cyc_d     = 1'b0;
                            gap_d     = 1'b1;
                        end
                    end else if (timeout_c) begin
                        state_d = ST_ERR;
                        cyc_d   = 1'b0;
                        ferr_d  = 1'b1;
                    end else begin
                        wait_tick_c = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (desc_ready) begin
                        valid_d = 1'b0;
                        if (ndar_dirty) begin
                            start_c = 1'b1;
                            clr_d   = 1'b1;
                        end else if (!ctrl_q.last && (next_q != '0)) begin
                            start_c     = 1'b1;
                            start_adr_c = {next_q, 3'b000};
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                ST_ERR: begin
                    cyc_d  = 1'b0;
                    ferr_d = 1'b1;
                end
                default: begin
                    state_d = ST_IDLE;
                    cyc_d   = 1'b0;
                    valid_d = 1'b0;
                    ferr_d  = 1'b0;
                end
            endcase

            // Launch beat 0 of a new descriptor.
            if (start_c) begin
                state_d      = ST_FETCH;
                base_d       = start_adr_c;
                adr_d        = start_adr_c;
                beat_d       = '0;
                cyc_d        = 1'b1;
                beat_start_c = 1'b1;
            end
        end
    end

    assign ndar_dirty_clear = clr_q;
    assign wbm_adr_o        = adr_q;
    assign wbm_sel_o        = {4{cyc_q}};
    assign wbm_cyc_o        = cyc_q;
    assign wbm_stb_o        = cyc_q;
    assign wbm_cab_o        = cyc_q;
    assign wbm_we_o         = 1'b0;
    assign desc_valid       = valid_q;
    assign desc_ctrl        = ctrl_q;
    assign desc_addr        = addr_q;
    assign desc_next        = next_q;
    assign desc_len         = len_q;
    assign fetch_err        = ferr_q;

endmodule

// File: tb/tb_desc_fetch_master.sv
// Directed bench for desc_fetch_master: vector table plus retry/error/abort/reset sequences.
module tb_desc_fetch_master;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic        ndar_dirty;
    logic [28:0] ndar;
    logic        ndar_dirty_clear;
    logic [31:0] wbm_adr_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_cab_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i, wbm_err_i, wbm_rty_i;
    logic        desc_valid;
    logic        desc_ready;
    logic [31:0] desc_ctrl;
    logic [28:0] desc_addr, desc_next;
    logic [23:0] desc_len;
    logic        fetch_err;

    desc_fetch_master #(.RTY_MAX(4), .TMO_MAX(255)) dut (
        .wb_clk_i         (wb_clk_i),
        .wb_rst_i         (wb_rst_i),
        .enable           (enable),
        .ndar_dirty       (ndar_dirty),
        .ndar             (ndar),
        .ndar_dirty_clear (ndar_dirty_clear),
        .wbm_adr_o        (wbm_adr_o),
        .wbm_sel_o        (wbm_sel_o),
        .wbm_cyc_o        (wbm_cyc_o),
        .wbm_stb_o        (wbm_stb_o),
        .wbm_we_o         (wbm_we_o),
        .wbm_cab_o        (wbm_cab_o),
        .wbm_dat_i        (wbm_dat_i),
        .wbm_ack_i        (wbm_ack_i),
        .wbm_err_i        (wbm_err_i),
        .wbm_rty_i        (wbm_rty_i),
        .desc_valid       (desc_valid),
        .desc_ready       (desc_ready),
        .desc_ctrl        (desc_ctrl),
        .desc_addr        (desc_addr),
        .desc_next        (desc_next),
        .desc_len         (desc_len),
        .fetch_err        (fetch_err)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    typedef struct {
        logic [31:0] base;
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] a0, a1, a2, a3;
        logic [31:0] e_ctrl;
        logic [28:0] e_addr, e_next;
        logic [23:0] e_len;
    } vec_t;

    vec_t        vecs[3];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ack_log[$];
    int          n_cmp = 0, n_bad = 0;
    int          clr_cnt = 0, gap_cnt = 0, valid_cnt = 0;
    logic        prev_cyc = 1'b0;
    logic        no_resp = 1'b0;
    logic [31:0] rty_adr = 32'h1, err_adr = 32'h1;
    int          rty_left = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_desc(input logic [31:0] b, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3);
        mem[b]          = w0;
        mem[b + 32'h4]  = w1;
        mem[b + 32'h8]  = w2;
        mem[b + 32'hC]  = w3;
    endtask

    // One clock: sample on the falling edge, then drive the slave reply for the next rising edge.
    task automatic tick();
        @(negedge wb_clk_i);
        if (ndar_dirty_clear) begin
            clr_cnt++;
            ndar_dirty = 1'b0;
        end
        if (desc_valid) valid_cnt++;
        if (prev_cyc && !wbm_cyc_o && !desc_valid && !fetch_err) gap_cnt++;
        prev_cyc  = wbm_cyc_o;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        wbm_rty_i = 1'b0;
        if (wbm_cyc_o && wbm_stb_o && !no_resp) begin
            if (wbm_adr_o == rty_adr && rty_left > 0) begin
                wbm_rty_i = 1'b1;
                rty_left--;
            end else if (wbm_adr_o == err_adr) begin
                wbm_err_i = 1'b1;
                wbm_ack_i = 1'b1;
            end else begin
                wbm_ack_i = 1'b1;
                wbm_dat_i = mem.exists(wbm_adr_o) ? mem[wbm_adr_o] : 32'h0;
                ack_log.push_back(wbm_adr_o);
            end
        end
    endtask

    task automatic start_fetch(input logic [31:0] b);
        ndar       = b[31:3];
        ndar_dirty = 1'b1;
    endtask

    // lat counts cycles from the first cycle with cyc high through the first cycle with desc_valid.
    task automatic wait_valid(input int budget, output int lat);
        bit done;
        done = 1'b0;
        lat  = 0;
        for (int i = 0; i < budget && !done; i++) begin
            tick();
            if (wbm_cyc_o || lat > 0) lat++;
            if (desc_valid) done = 1'b1;
        end
        if (!done) lat = -1;
    endtask

    task automatic wait_ferr(input int budget);
        for (int i = 0; i < budget && !fetch_err; i++) tick();
    endtask

    task automatic accept();
        desc_ready = 1'b1;
        tick();
        desc_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int hi;

        vecs[0] = '{32'h0000_1000, 32'h0000_0001, 32'h0000_2000, 32'h0000_0000, 32'h0000_0040,
                    32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C,
                    32'h0000_0001, 29'h0000_0400, 29'h0, 24'h00_0040};
        vecs[1] = '{32'h8000_0008, 32'hABCD_5503, 32'hFFFF_FFFF, 32'h1234_5677, 32'hFF12_3456,
                    32'h8000_0008, 32'h8000_000C, 32'h8000_0010, 32'h8000_0014,
                    32'hABCD_5503, 29'h1FFF_FFFF, 29'h0246_8ACE, 24'h12_3456};
        vecs[2] = '{32'hFFFF_FFF8, 32'h0000_0101, 32'h0000_0008, 32'h0000_0000, 32'h00FF_FFFF,
                    32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004,
                    32'h0000_0101, 29'h0000_0001, 29'h0, 24'hFF_FFFF};

        wb_rst_i   = 1'b1;
        enable     = 1'b0;
        ndar_dirty = 1'b0;
        ndar       = '0;
        wbm_dat_i  = '0;
        wbm_ack_i  = 1'b0;
        wbm_err_i  = 1'b0;
        wbm_rty_i  = 1'b0;
        desc_ready = 1'b0;
        repeat (2) @(negedge wb_clk_i);

        check("rst_bus_ctl", {wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_we_o, wbm_sel_o}, 64'h0);
        check("rst_adr", wbm_adr_o, 64'h0);
        check("rst_flags", {desc_valid, fetch_err, ndar_dirty_clear}, 64'h0);
        check("rst_desc", {desc_ctrl, desc_len}, 64'h0);
        wb_rst_i = 1'b0;
        enable   = 1'b1;
        tick();

        // Zero-wait slave, one descriptor per table row, all with last=1.
        for (int v = 0; v < 3; v++) begin
            set_desc(vecs[v].base, vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].w3);
            ack_log.delete();
            clr_cnt = 0;
            start_fetch(vecs[v].base);
            wait_valid(40, lat);
            check($sformatf("v%0d_latency", v), lat, 64'd5);
            check($sformatf("v%0d_beats", v), ack_log.size(), 64'd4);
            if (ack_log.size() >= 4) begin
                check($sformatf("v%0d_adr01", v), {ack_log[0], ack_log[1]}, {vecs[v].a0, vecs[v].a1});
                check($sformatf("v%0d_adr23", v), {ack_log[2], ack_log[3]}, {vecs[v].a2, vecs[v].a3});
            end
            check($sformatf("v%0d_ctrl", v), desc_ctrl, vecs[v].e_ctrl);
            check($sformatf("v%0d_addr", v), desc_addr, vecs[v].e_addr);
            check($sformatf("v%0d_next", v), desc_next, vecs[v].e_next);
            check($sformatf("v%0d_len", v), desc_len, vecs[v].e_len);
            check($sformatf("v%0d_clr_once", v), clr_cnt, 64'd1);
            accept();
            tick();
            check($sformatf("v%0d_idle", v), {wbm_cyc_o, desc_valid}, 64'h0);
        end

        // Chain: last=0 and next=0x3000 restarts without a new ndar.
        set_desc(32'h0000_1000, 32'h0000_0000, 32'h0000_2000, 32'h0000_3000, 32'h0000_0010);
        set_desc(32'h0000_3000, 32'h0000_0001, 32'h0000_4000, 32'h0000_0000, 32'h0000_0020);
        clr_cnt = 0;
        start_fetch(32'h0000_1000);
        wait_valid(40, lat);
        check("chain_len1", desc_len, 64'h10);
        check("chain_next1", desc_next, 64'h600);
        accept();
        check("chain_restart", {wbm_cyc_o, wbm_adr_o}, {1'b1, 32'h0000_3000});
        wait_valid(40, lat);
        check("chain_len2", desc_len, 64'h20);
        accept();
        tick();
        check("chain_clr_once", clr_cnt, 64'd1);
        check("chain_idle", {wbm_cyc_o, desc_valid}, 64'h0);

        // Three retries on beat 2: three one-cycle gaps, fetch completes.
        set_desc(32'h0000_5000, 32'h0000_0001, 32'h0000_5100, 32'h0000_0000, 32'h0000_0077);
        rty_adr  = 32'h0000_5008;
        rty_left = 3;
        gap_cnt  = 0;
        start_fetch(32'h0000_5000);
        wait_valid(60, lat);
        check("rty3_gaps", gap_cnt, 64'd3);
        check("rty3_data", {desc_addr, desc_len}, {29'h0A20, 24'h77});
        check("rty3_no_err", fetch_err, 64'h0);
        accept();
        tick();

        // Four retries: fetch fails and the error is sticky until enable drops.
        rty_left = 4;
        start_fetch(32'h0000_5000);
        wait_ferr(60);
        check("rty4_err", {fetch_err, wbm_cyc_o}, {1'b1, 1'b0});
        repeat (3) tick();
        check("rty4_sticky", {fetch_err, wbm_cyc_o, desc_valid}, {1'b1, 1'b0, 1'b0});
        enable = 1'b0;
        tick();
        check("rty4_cleared", fetch_err, 64'h0);
        enable  = 1'b1;
        rty_adr = 32'h1;
        tick();

        // ack and err together on beat 1 count as err.
        err_adr = 32'h0000_5004;
        start_fetch(32'h0000_5000);
        wait_ferr(40);
        check("ackerr_err", {fetch_err, wbm_cyc_o, desc_valid}, {1'b1, 1'b0, 1'b0});
        enable = 1'b0;
        tick();
        enable  = 1'b1;
        err_adr = 32'h1;
        tick();

        // Silent slave: cyc stays up for exactly 255 wait cycles.
        no_resp = 1'b1;
        hi      = 0;
        start_fetch(32'h0000_5000);
        for (int i = 0; i < 400 && !fetch_err; i++) begin
            tick();
            if (wbm_cyc_o) hi++;
        end
        check("tmo_err", {fetch_err, wbm_cyc_o}, {1'b1, 1'b0});
        check("tmo_cycles", hi, 64'd255);
        enable = 1'b0;
        tick();
        check("tmo_cleared", {fetch_err, wbm_cyc_o}, 64'h0);
        enable  = 1'b1;
        no_resp = 1'b0;
        tick();

        // enable drops once beat 1 is on the bus.
        set_desc(32'h0000_6000, 32'h0000_0001, 32'h0000_6100, 32'h0000_0000, 32'h0000_0099);
        start_fetch(32'h0000_6000);
        for (int i = 0; i < 20 && !(wbm_cyc_o && wbm_adr_o == 32'h0000_6004); i++) tick();
        check("drop_beat1_seen", wbm_adr_o, 64'h6004);
        enable    = 1'b0;
        valid_cnt = 0;
        clr_cnt   = 0;
        tick();
        check("drop_cyc_low", {wbm_cyc_o, wbm_stb_o, desc_valid}, 64'h0);
        ndar       = 29'(32'h0000_7000 >> 3);
        ndar_dirty = 1'b1;
        repeat (10) tick();
        check("drop_no_valid", valid_cnt, 64'd0);
        check("drop_dirty_kept", clr_cnt, 64'd0);
        check("drop_bus_idle", wbm_cyc_o, 64'h0);
        set_desc(32'h0000_7000, 32'h0000_0001, 32'h0000_7100, 32'h0000_0000, 32'h0000_00AB);
        enable = 1'b1;
        wait_valid(40, lat);
        check("drop_refetch_len", desc_len, 64'hAB);
        check("drop_refetch_clr", clr_cnt, 64'd1);
        accept();
        tick();

        // Reset in the middle of a burst clears outputs without waiting for an edge.
        no_resp = 1'b1;
        start_fetch(32'h0000_7000);
        for (int i = 0; i < 10 && !wbm_cyc_o; i++) tick();
        repeat (2) tick();
        check("midrst_pre_cyc", wbm_cyc_o, 64'h1);
        #2 wb_rst_i = 1'b1;
        #1;
        check("midrst_bus", {wbm_cyc_o, wbm_stb_o, wbm_cab_o, wbm_sel_o}, 64'h0);
        check("midrst_adr", wbm_adr_o, 64'h0);
        check("midrst_desc", {desc_len, desc_addr}, 64'h0);
        check("midrst_flags", {desc_valid, fetch_err, ndar_dirty_clear}, 64'h0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        no_resp  = 1'b0;
        prev_cyc = 1'b0;
        repeat (3) tick();
        check("midrst_stays_idle", {wbm_cyc_o, desc_valid}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
